// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath (MAR/MDR side) and the
// memory responder. The requester drives the address, data and strobes;
// the responder returns read data and status.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] MAR_addr;
  logic [DATA_WIDTH-1:0] MDR_wdata;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  mem_ready;
  logic                  busy;
  logic                  err;

  modport master (
    output MAR_addr, MDR_wdata, read, write,
    input  Mdatain, mem_ready, busy, err
  );

  modport slave (
    input  MAR_addr, MDR_wdata, read, write,
    output Mdatain, mem_ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed synchronous RAM behind MAR/MDR. A request is latched in
// IDLE, held for WAIT_STATES extra cycles, then performed with a one-cycle
// mem_ready pulse. The responder parks in DONE until both strobes drop so a
// level-held strobe cannot retrigger a second access.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic            clock,
  input  logic            clear,
  mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Counter is 4 bits wide: WAIT_STATES is limited to 0..15.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_write_q, is_write_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_we;
  logic                  mem_re;

  // Storage is deliberately left without reset so it maps onto RAM.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Next-state, latch and access-strobe logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.read ^ bus.write) begin
          addr_d     = bus.MAR_addr;
          wdata_d    = bus.MDR_wdata;
          is_write_d = bus.write;
          cnt_d      = WAIT_LOAD;
          state_d    = S_WAIT;
        end else if (bus.read && bus.write) begin
          // Conflicting request: flag it and skip the access entirely.
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          ready_d = 1'b1;
          state_d = S_DONE;
          if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            mem_re  = 1'b1;
            rdata_d = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (!bus.read && !bus.write) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any request in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // RAM write port; only fires on the completing WAIT edge.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.Mdatain   = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != S_IDLE);

  // mem_re only documents the read strobe; the data path uses rdata_d.
  logic unused_re;
  assign unused_re = mem_re;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder. Two instances run side
// by side (WAIT_STATES=2 and WAIT_STATES=0) and are compared every cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_responder;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  logic          rd_s   [2];
  logic          wr_s   [2];
  logic [AW-1:0] addr_s [2];
  logic [DW-1:0] wd_s   [2];
  logic          rdy_o  [2];
  logic          err_o  [2];
  logic          busy_o [2];
  logic [DW-1:0] mdat_o [2];

  mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.read      = rd_s[0];
  assign bus0.write     = wr_s[0];
  assign bus0.MAR_addr  = addr_s[0];
  assign bus0.MDR_wdata = wd_s[0];
  assign bus1.read      = rd_s[1];
  assign bus1.write     = wr_s[1];
  assign bus1.MAR_addr  = addr_s[1];
  assign bus1.MDR_wdata = wd_s[1];
  assign rdy_o[0]  = bus0.mem_ready;
  assign err_o[0]  = bus0.err;
  assign busy_o[0] = bus0.busy;
  assign mdat_o[0] = bus0.Mdatain;
  assign rdy_o[1]  = bus1.mem_ready;
  assign err_o[1]  = bus1.err;
  assign busy_o[1] = bus1.busy;
  assign mdat_o[1] = bus1.Mdatain;

  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2)) dut0 (
    .clock(clock), .clear(clear), .bus(bus0.slave));
  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut1 (
    .clock(clock), .clear(clear), .bus(bus1.slave));

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int            cyc = 0;
  bit            act      [2];
  int            done_at  [2];
  int            rel_from [2];
  bit            m_wr     [2];
  logic [AW-1:0] m_addr   [2];
  logic [DW-1:0] m_wd     [2];
  logic [DW-1:0] mmem     [2][2**AW];
  logic [DW-1:0] e_mdat   [2];
  bit            e_rdy    [2];
  bit            e_err    [2];

  always @(posedge clock) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      e_rdy[d] = 1'b0;
      e_err[d] = 1'b0;
      if (!clear) begin
        act[d]    = 1'b0;
        e_mdat[d] = '0;
      end else if (!act[d]) begin
        if (rd_s[d] ^ wr_s[d]) begin
          act[d]      = 1'b1;
          done_at[d]  = cyc + ws_of(d) + 1;
          rel_from[d] = done_at[d] + 1;
          m_wr[d]     = wr_s[d];
          m_addr[d]   = addr_s[d];
          m_wd[d]     = wd_s[d];
        end else if (rd_s[d] && wr_s[d]) begin
          act[d]      = 1'b1;
          e_err[d]    = 1'b1;
          done_at[d]  = -1;
          rel_from[d] = cyc + 1;
        end
      end else begin
        if (cyc == done_at[d]) begin
          e_rdy[d] = 1'b1;
          if (m_wr[d]) mmem[d][m_addr[d]] = m_wd[d];
          else         e_mdat[d] = mmem[d][m_addr[d]];
        end else if (cyc >= rel_from[d] && !rd_s[d] && !wr_s[d]) begin
          act[d] = 1'b0;
        end
      end
    end
  end

  always @(negedge clear) begin
    for (int d = 0; d < 2; d++) begin
      act[d]    = 1'b0;
      e_rdy[d]  = 1'b0;
      e_err[d]  = 1'b0;
      e_mdat[d] = '0;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always begin
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d mem_ready", d), 32'(rdy_o[d]),  32'(e_rdy[d]));
      chk($sformatf("dut%0d err", d),       32'(err_o[d]),  32'(e_err[d]));
      chk($sformatf("dut%0d busy", d),      32'(busy_o[d]), 32'(act[d]));
      chk($sformatf("dut%0d Mdatain", d),   mdat_o[d],      e_mdat[d]);
    end
  end

  // ---------------- requester ----------------
  task automatic xact(input int d, input bit r, input bit w,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int hold, input bit scramble,
                      output int lat, output logic [DW-1:0] rdat,
                      output int npulse, output int nerr, output bit busy_held);
    int k;
    bit conflict;
    conflict  = r && w;
    addr_s[d] = a;
    wd_s[d]   = wd;
    rd_s[d]   = r;
    wr_s[d]   = w;
    k         = cyc + 1;
    lat       = -1;
    rdat      = '0;
    npulse    = 0;
    nerr      = 0;
    busy_held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #3;
      if (scramble) begin
        addr_s[d] = AW'($urandom);
        wd_s[d]   = $urandom;
      end
      if (rdy_o[d]) begin
        npulse++;
        if (lat < 0) begin
          lat  = cyc - k;
          rdat = mdat_o[d];
        end
      end
      if (err_o[d]) nerr++;
      if (conflict || lat >= 0) break;
    end
    if (!conflict && lat < 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d ready timeout: got no mem_ready, required one within 40 cycles", d);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #3;
      if (rdy_o[d]) npulse++;
      if (err_o[d]) nerr++;
      if (!busy_o[d]) busy_held = 1'b0;
    end
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
    @(posedge clock);
    #3;
    if (rdy_o[d]) npulse++;
    if (err_o[d]) nerr++;
    $display("xact dut%0d %s addr=%h wdata=%h lat=%0d rdata=%h pulses=%0d errs=%0d",
             d, conflict ? "CONFLICT" : (w ? "WRITE" : "READ"), a, wd, lat, rdat, npulse, nerr);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, np, ne;
    logic [DW-1:0] rdat;
    bit bh;
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wd_s[d] = '0;
    end

    // Reset held: strobes toggle, nothing may respond.
    repeat (5) begin
      @(posedge clock);
      #3;
      for (int d = 0; d < 2; d++) begin
        rd_s[d] = 1'($urandom); wr_s[d] = 1'($urandom); addr_s[d] = AW'($urandom);
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset busy dut%0d", d),  32'(busy_o[d]), 32'd0);
      chk($sformatf("reset ready dut%0d", d), 32'(rdy_o[d]),  32'd0);
      chk($sformatf("reset err dut%0d", d),   32'(err_o[d]),  32'd0);
      chk($sformatf("reset Mdatain dut%0d", d), mdat_o[d],    32'd0);
      rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    end
    clear = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #3;
    end
    chk("idle after release dut0", 32'(busy_o[0]), 32'd0);

    // Preload a small address pool on both instances.
    for (int a = 0; a < 32; a++) begin
      for (int d = 0; d < 2; d++) begin
        xact(d, 1'b0, 1'b1, AW'(a), $urandom, 0, 1'b0, lat, rdat, np, ne, bh);
      end
    end

    // Write then read with WAIT_STATES=2.
    xact(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 0, 1'b0, lat, rdat, np, ne, bh);
    chk("write latency", 32'(lat), 32'd3);
    chk("write one pulse", 32'(np), 32'd1);
    xact(0, 1'b1, 1'b0, 9'h005, 32'h0, 0, 1'b0, lat, rdat, np, ne, bh);
    chk("read back 0x005", rdat, 32'hDEADBEEF);
    chk("read latency", 32'(lat), 32'd3);

    // Hold-off: read strobe held six cycles past completion.
    xact(0, 1'b1, 1'b0, 9'h005, 32'h0, 6, 1'b0, lat, rdat, np, ne, bh);
    chk("holdoff pulses", 32'(np), 32'd1);
    chk("holdoff busy held", 32'(bh), 32'd1);
    chk("holdoff idle after drop", 32'(busy_o[0]), 32'd0);

    // Conflict leaves memory untouched.
    xact(0, 1'b0, 1'b1, 9'h010, 32'h12345678, 0, 1'b0, lat, rdat, np, ne, bh);
    xact(0, 1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, 0, 1'b0, lat, rdat, np, ne, bh);
    chk("conflict err pulses", 32'(ne), 32'd1);
    chk("conflict no ready", 32'(np), 32'd0);
    xact(0, 1'b1, 1'b0, 9'h010, 32'h0, 0, 1'b0, lat, rdat, np, ne, bh);
    chk("after conflict 0x010", rdat, 32'h12345678);

    // Reset during WAIT aborts the write.
    xact(0, 1'b0, 1'b1, 9'h020, 32'h0, 0, 1'b0, lat, rdat, np, ne, bh);
    addr_s[0] = 9'h020;
    wd_s[0]   = 32'hCAFEF00D;
    wr_s[0]   = 1'b1;
    @(posedge clock);
    #3;
    clear = 1'b0;
    #2;
    chk("async reset Mdatain", mdat_o[0], 32'd0);
    chk("async reset busy", 32'(busy_o[0]), 32'd0);
    @(posedge clock);
    #3;
    wr_s[0] = 1'b0;
    clear   = 1'b1;
    @(posedge clock);
    #3;
    xact(0, 1'b1, 1'b0, 9'h020, 32'h0, 0, 1'b0, lat, rdat, np, ne, bh);
    chk("aborted write 0x020", rdat, 32'h0);

    // Zero wait states.
    xact(1, 1'b0, 1'b1, 9'h007, 32'hA5A50F0F, 0, 1'b0, lat, rdat, np, ne, bh);
    chk("ws0 write latency", 32'(lat), 32'd1);
    xact(1, 1'b1, 1'b0, 9'h007, 32'h0, 0, 1'b0, lat, rdat, np, ne, bh);
    chk("ws0 read latency", 32'(lat), 32'd1);
    chk("ws0 read data", rdat, 32'hA5A50F0F);

    // Address changes during WAIT are ignored.
    xact(0, 1'b0, 1'b1, 9'h030, 32'h0BADF00D, 0, 1'b1, lat, rdat, np, ne, bh);
    xact(0, 1'b1, 1'b0, 9'h030, 32'h0, 0, 1'b1, lat, rdat, np, ne, bh);
    chk("scrambled addr read", rdat, 32'h0BADF00D);

    // Randomized traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      int d, kind, hold;
      logic [AW-1:0] a;
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(0, 3));
      a    = AW'($urandom_range(0, 31));
      if (kind < 5) begin
        xact(d, 1'b1, 1'b0, a, $urandom, hold, 1'($urandom), lat, rdat, np, ne, bh);
        chk("rand read latency", 32'(lat), 32'(ws_of(d) + 1));
        chk("rand read data", rdat, mmem[d][a]);
      end else if (kind < 9) begin
        xact(d, 1'b0, 1'b1, a, $urandom, hold, 1'($urandom), lat, rdat, np, ne, bh);
        chk("rand write latency", 32'(lat), 32'(ws_of(d) + 1));
      end else begin
        xact(d, 1'b1, 1'b1, a, $urandom, hold, 1'b0, lat, rdat, np, ne, bh);
        chk("rand conflict err", 32'(ne), 32'd1);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #3;
      end
    end

    repeat (2) begin
      @(posedge clock);
      #3;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed synchronous RAM that answers the datapath's memory requests. It sits on the far side of MAR/MDR: it samples the `read`/`write` strobes, waits a parameterised number of cycles, then performs the access. For a read it returns the word on `Mdatain`. It reports completion with a one-cycle `mem_ready` pulse, which the control sequencer uses to leave its memory-wait step.

## Interface
- `ADDR_WIDTH`, default 9: word address width; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: word width.
- `WAIT_STATES`, default 2: extra cycles before an access completes; legal range 0..15.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `clear`  in  1  reset, asynchronous, active-low.
- `MAR_addr`  in  ADDR_WIDTH  word address, driven from MAR.
- `MDR_wdata`  in  DATA_WIDTH  write data, driven from MDR.
- `read`  in  1  read request strobe, level-held by the requester until `mem_ready`.
- `write`  in  1  write request strobe, level-held by the requester until `mem_ready`.
- `Mdatain`  out  DATA_WIDTH  read data, registered, feeds the MDR input mux.
- `mem_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever state is not IDLE.
- `err`  out  1  one-cycle pulse when `read` and `write` are both high.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE**, at an edge:
  - `read` xor `write` high: latch `MAR_addr`, `MDR_wdata` and direction; load counter with WAIT_STATES; go to WAIT.
  - Both high: `err` goes high for one cycle; no latch and no access; go to DONE.
  - Neither high: stay in IDLE.
- **WAIT**, at an edge:
  - Counter == 0: perform the access, set `mem_ready` to 1, go to DONE.
    - Write: mem[latched addr] <= latched data.
    - Read: `Mdatain` <= mem[latched addr].
  - Otherwise: decrement the counter.
- **DONE**, at an edge:
  - `mem_ready` and `err` clear to 0.
  - Both strobes low: go to IDLE.
  - Otherwise: stay in DONE. The requester must drop its strobe before it can start a new request.
- Strobe and address changes during WAIT or DONE are ignored; the latched values are used.
- `Mdatain` holds the last read word until the next read completes. Writes never change it.
- Memory array is not reset. Contents are undefined until written, or preloaded by `$readmemh` in simulation only.
- Address width exactly covers the depth, so no out-of-range case exists.

## Timing
- Reset (`clear` low), effective immediately regardless of clock:
  - state = IDLE, counter = 0.
  - `Mdatain` = 0, `mem_ready` = 0, `busy` = 0, `err` = 0.
- Reset during WAIT aborts the request; the memory array is unmodified.
- Reset after the completing edge does not undo a write that has already happened.
- Latency: request sampled at edge k → access and `mem_ready` rise at edge k+WAIT_STATES+1.
  - `mem_ready` is high for exactly one cycle.
  - WAIT_STATES=0 gives ready one cycle after the request.
- `busy` rises at edge k and falls at the first edge in DONE where both strobes are low.
- Minimum spacing between requests: one cycle with both strobes low.
- Back-to-back read of a just-written address returns the new data.
- `err`: set at the sampling edge; cleared at the next edge (in DONE).

## Test plan
- Reset: hold `clear`=0, toggle strobes → all outputs 0, `busy`=0. Release `clear` → no activity until a strobe is asserted.
- Write then read, WAIT_STATES=2:
  - Write 0xDEADBEEF to addr 0x005 with `write` sampled at edge k → `mem_ready` high only between edges k+3 and k+4.
  - Drop the strobe, then read addr 0x005 → `Mdatain`=0xDEADBEEF when `mem_ready` pulses.
- Hold-off: keep `read` high for 6 cycles after `mem_ready` → exactly one `mem_ready` pulse and `busy` stays high. Drop `read` → IDLE the next cycle.
- Conflict: `read`=`write`=1 on addr 0x010, which holds 0x12345678 → one-cycle `err`, no `mem_ready`, addr 0x010 still reads 0x12345678.
- Mid-operation reset: write 0xCAFEF00D to addr 0x020 (previously 0x0) and pulse `clear` low during WAIT → reading addr 0x020 returns 0x0 and `Mdatain` resets to 0.
- Zero wait, WAIT_STATES=0: a read sampled at edge k gives `mem_ready` at edge k+1. Also change `MAR_addr` during WAIT (WAIT_STATES=2) → the data returned is from the originally latched address.
